program_loader: RTL and testbench

Boot-time program loader that sits directly upstream of `processor`. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words. It writes them into instruction memory starting at word address 0, verifies a trailing XOR checksum, and holds the core's `start_up` high until a verified image is in place.

---
 rtl/program_loader_pkg.sv | 22 ++
 rtl/program_loader_if.sv | 25 ++
 rtl/program_loader_word_assembler.sv | 34 +++
 rtl/program_loader.sv | 124 ++++++++++++
 tb/tb_program_loader.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/program_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package program_loader_pkg;

  localparam int LD_WORD_W = 32;
  localparam int LD_BYTE_W = 8;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_HDR,
    LD_LOAD,
    LD_CHK,
    LD_RELEASE,
    LD_RUN,
    LD_ERR
  } ld_state_t;

  // The byte stream is only accepted while a word is being collected.
  function automatic logic is_rx_state(ld_state_t s);
    return (s == LD_HDR) || (s == LD_LOAD) || (s == LD_CHK);
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream handshake plus instruction-memory write bus of the loader.
interface program_loader_if
  import program_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) ();

  logic [LD_BYTE_W-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 imem_we;
  logic [ADDR_W-1:0]    imem_addr;
  logic [LD_WORD_W-1:0] imem_wdata;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/program_loader_word_assembler.sv
// Packs accepted bytes big-endian into 32-bit words; word_done flags the 4th byte.
module word_assembler
  import program_loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 accept,
  input  logic [LD_BYTE_W-1:0] byte_in,
  output logic [LD_WORD_W-1:0] word,
  output logic                 word_done
);

  logic [1:0]           byte_cnt;
  logic [LD_WORD_W-1:0] shreg;

  // The completed word includes the byte being accepted this cycle.
  assign word      = {shreg[LD_WORD_W-LD_BYTE_W-1:0], byte_in};
  assign word_done = accept && (byte_cnt == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= 2'd0;
      shreg    <= '0;
    end else if (clear) begin
      byte_cnt <= 2'd0;
      shreg    <= '0;
    end else if (accept) begin
      byte_cnt <= byte_cnt + 2'd1;
      shreg    <= word;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed, XOR-checksummed image into instruction memory and
// releases the core once the checksum matches.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic             clk,
  input  logic             start_up_n,
  program_loader_if.master bus,
  output logic             core_start_up,
  output logic             done,
  output logic             err
);

  localparam logic [LD_WORD_W-1:0] MAX_WORDS = LD_WORD_W'(1) << ADDR_W;

  ld_state_t            state;
  logic [ADDR_W:0]      words_left;
  logic [ADDR_W-1:0]    imem_addr;
  logic [LD_WORD_W-1:0] imem_wdata;
  logic [LD_WORD_W-1:0] acc;
  logic [LD_WORD_W-1:0] word;
  logic                 imem_we;
  logic                 rx_ready;
  logic                 accept;
  logic                 word_done;
  logic                 clear;

  assign rx_ready       = is_rx_state(state);
  assign accept         = bus.rx_valid && rx_ready;
  assign bus.rx_ready   = rx_ready;
  assign bus.imem_we    = imem_we;
  assign bus.imem_addr  = imem_addr;
  assign bus.imem_wdata = imem_wdata;

  word_assembler u_asm (
    .clk       (clk),
    .rst_n     (start_up_n),
    .clear     (clear),
    .accept    (accept),
    .byte_in   (bus.rx_data),
    .word      (word),
    .word_done (word_done)
  );

  // Asserted exactly on the cycles whose closing edge changes state.
  always_comb begin
    clear = 1'b0;
    case (state)
      LD_IDLE, LD_RELEASE: clear = 1'b1;
      LD_HDR, LD_CHK:      clear = word_done;
      LD_LOAD:             clear = word_done && (words_left == (ADDR_W+1)'(1));
      default:             clear = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge start_up_n) begin
    if (!start_up_n) begin
      state         <= LD_IDLE;
      words_left    <= '0;
      imem_addr     <= '0;
      imem_wdata    <= '0;
      imem_we       <= 1'b0;
      acc           <= '0;
      core_start_up <= 1'b1;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      // Advance the address only after a write, so the last write leaves it in range.
      if (state == LD_LOAD && imem_we)
        imem_addr <= imem_addr + ADDR_W'(1);
      case (state)
        LD_IDLE: state <= LD_HDR;
        LD_HDR: begin
          if (word_done) begin
            if (word > MAX_WORDS) begin
              state <= LD_ERR;
              err   <= 1'b1;
            end else if (word == '0) begin
              state <= LD_CHK;
            end else begin
              state      <= LD_LOAD;
              words_left <= word[ADDR_W:0];
              imem_addr  <= '0;
            end
          end
        end
        LD_LOAD: begin
          if (word_done) begin
            imem_we    <= 1'b1;
            imem_wdata <= word;
            acc        <= acc ^ word;
            words_left <= words_left - (ADDR_W+1)'(1);
            if (words_left == (ADDR_W+1)'(1))
              state <= LD_CHK;
          end
        end
        LD_CHK: begin
          if (word_done) begin
            if (word == acc) begin
              state <= LD_RELEASE;
            end else begin
              state <= LD_ERR;
              err   <= 1'b1;
            end
          end
        end
        LD_RELEASE: begin
          state         <= LD_RUN;
          core_start_up <= 1'b0;
          done          <= 1'b1;
        end
        LD_RUN, LD_ERR: ;
        default: begin
          state <= LD_ERR;
          err   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes are queued as words are sent.
module tb_program_loader;

  localparam int ADDR_W = 10;

  logic clk = 1'b0;
  logic start_up_n = 1'b0;
  logic core_start_up, done, err;

  program_loader_if #(.ADDR_W(ADDR_W)) bus ();

  program_loader #(.ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .start_up_n    (start_up_n),
    .bus           (bus),
    .core_start_up (core_start_up),
    .done          (done),
    .err           (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad = 0;
  int  write_count = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Every write strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (start_up_n && bus.imem_we) begin
      write_count++;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_write", 32'd1, 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        checkOutput("wr_addr", 32'(bus.imem_addr), 32'(e.addr));
        checkOutput("wr_data", bus.imem_wdata, e.data);
      end
    end
  end

  // Called right after a falling edge; returns right after the falling edge that follows acceptance.
  task automatic applyStimulus(input logic [7:0] b, input int max_gap);
    int  gap;
    bit  accepted;
    gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    if (gap > 0) begin
      bus.rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 50 && !accepted; i++) begin
      accepted = bus.rx_ready;
      @(negedge clk);
    end
    if (!accepted) checkOutput("rx_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic sendWord(input logic [31:0] w, input bit is_prog,
                          input logic [ADDR_W-1:0] addr, input int max_gap);
    for (int k = 3; k >= 0; k--) begin
      if (is_prog && k == 0) exp_q.push_back('{addr: addr, data: w});
      applyStimulus(w[8*k +: 8], max_gap);
    end
    if (is_prog) checkOutput("we_latency", 32'(bus.imem_we), 32'd1);
  endtask

  task automatic doReset();
    bit up;
    start_up_n   = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    exp_q.delete();
    repeat (2) @(negedge clk);
    checkOutput("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
    checkOutput("rst_core_start_up", 32'(core_start_up), 32'd1);
    checkOutput("rst_imem_we", 32'(bus.imem_we), 32'd0);
    checkOutput("rst_imem_addr", 32'(bus.imem_addr), 32'd0);
    checkOutput("rst_imem_wdata", bus.imem_wdata, 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    start_up_n = 1'b1;
    write_count = 0;
    checkOutput("idle_rx_ready", 32'(bus.rx_ready), 32'd0);
    up = 1'b0;
    for (int i = 0; i < 4 && !up; i++) begin
      @(negedge clk);
      up = bus.rx_ready;
    end
    checkOutput("hdr_rx_ready", 32'(up), 32'd1);
  endtask

  task automatic runImage(input logic [31:0] hdr, input int n, input logic [31:0] w0,
                          input logic [31:0] w1, input logic [31:0] sum, input int max_gap);
    sendWord(hdr, 1'b0, '0, max_gap);
    checkOutput("hold_during_load", 32'(core_start_up), 32'd1);
    if (n > 0) sendWord(w0, 1'b1, ADDR_W'(0), max_gap);
    if (n > 1) sendWord(w1, 1'b1, ADDR_W'(1), max_gap);
    sendWord(sum, 1'b0, '0, max_gap);
    bus.rx_valid = 1'b0;
  endtask

  task automatic checkReleased(input string tag, input int writes);
    checkOutput({tag, "_release_hold"}, 32'(core_start_up), 32'd1);
    checkOutput({tag, "_release_done"}, 32'(done), 32'd0);
    @(negedge clk);
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_core_start_up"}, 32'(core_start_up), 32'd0);
    checkOutput({tag, "_run_rx_ready"}, 32'(bus.rx_ready), 32'd0);
    checkOutput({tag, "_err"}, 32'(err), 32'd0);
    checkOutput({tag, "_writes"}, 32'(write_count), 32'(writes));
    checkOutput({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    $display("[TB] nominal load");
    doReset();
    runImage(32'h2, 2, 32'h20080005, 32'h01094020, 32'h21014025, 0);
    checkReleased("nominal", 2);

    $display("[TB] bad checksum");
    doReset();
    runImage(32'h2, 2, 32'h20080005, 32'h01094020, 32'h21014024, 0);
    checkOutput("badsum_err", 32'(err), 32'd1);
    checkOutput("badsum_core_start_up", 32'(core_start_up), 32'd1);
    checkOutput("badsum_rx_ready", 32'(bus.rx_ready), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("badsum_done", 32'(done), 32'd0);
    checkOutput("badsum_err_sticky", 32'(err), 32'd1);
    checkOutput("badsum_writes", 32'(write_count), 32'd2);

    $display("[TB] empty image");
    doReset();
    runImage(32'h0, 0, 32'h0, 32'h0, 32'h0, 0);
    checkReleased("empty", 0);

    $display("[TB] oversize header");
    doReset();
    sendWord(32'h401, 1'b0, '0, 0);
    bus.rx_valid = 1'b0;
    checkOutput("oversize_err", 32'(err), 32'd1);
    checkOutput("oversize_rx_ready", 32'(bus.rx_ready), 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("oversize_writes", 32'(write_count), 32'd0);
    checkOutput("oversize_core_start_up", 32'(core_start_up), 32'd1);

    $display("[TB] maximum legal header");
    doReset();
    sendWord(32'h400, 1'b0, '0, 0);
    bus.rx_valid = 1'b0;
    checkOutput("maxlen_err", 32'(err), 32'd0);
    checkOutput("maxlen_rx_ready", 32'(bus.rx_ready), 32'd1);

    $display("[TB] stalled stream");
    doReset();
    runImage(32'h2, 2, 32'h20080005, 32'h01094020, 32'h21014025, 5);
    checkReleased("stalled", 2);

    $display("[TB] reset mid-load");
    doReset();
    sendWord(32'h2, 1'b0, '0, 0);
    applyStimulus(8'h20, 0);
    applyStimulus(8'h08, 0);
    start_up_n   = 1'b0;
    bus.rx_valid = 1'b0;
    #1;
    checkOutput("midrst_rx_ready", 32'(bus.rx_ready), 32'd0);
    checkOutput("midrst_core_start_up", 32'(core_start_up), 32'd1);
    checkOutput("midrst_imem_we", 32'(bus.imem_we), 32'd0);
    checkOutput("midrst_imem_addr", 32'(bus.imem_addr), 32'd0);
    checkOutput("midrst_imem_wdata", bus.imem_wdata, 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    checkOutput("midrst_err", 32'(err), 32'd0);
    doReset();
    runImage(32'h2, 2, 32'h20080005, 32'h01094020, 32'h21014025, 0);
    checkReleased("reload", 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
